// File: rtl/arith_pkg.sv
// arith_pkg: shared types, defaults and the signed-overflow helper for the add/sub pipeline
package arith_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int STAGES_DEF = 4;

    typedef struct packed {
        logic carry_out;
        logic overflow;
        logic zero;
    } flags_t;

    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/add_chunk.sv
// add_chunk: combinational CW-bit adder with carry in and carry out
module add_chunk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] s,
    output logic          cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};

endmodule

// File: rtl/pipe_add_sub.sv
// pipe_add_sub: pipelined add/sub, one CW-bit chunk of carry ripple per stage; PIPE_ADD_SUB_SAT_EN adds a sat port for clamped results
module pipe_add_sub
    import arith_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STAGES = STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             carry_in,
`ifdef PIPE_ADD_SUB_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || WIDTH % STAGES != 0) begin : g_bad
        $error("pipe_add_sub: illegal WIDTH/STAGES combination");
    end

    logic             advance;
    logic [WIDTH-1:0] x_a [STAGES];
    logic [WIDTH-1:0] x_b [STAGES];
    logic [WIDTH-1:0] x_s [STAGES];
    logic             x_c [STAGES];
    logic             x_v [STAGES];
    logic             x_sat [STAGES];
    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             r_c [STAGES];
    logic             r_v [STAGES];
    logic             r_sat [STAGES];
    logic [CW-1:0]    cs [STAGES];
    logic             co [STAGES];
    logic [WIDTH-1:0] raw;
    flags_t           fl;

    assign advance  = !r_v[L] || out_ready;
    assign in_ready = advance;

    assign x_a[0] = a;
    assign x_b[0] = b ^ {WIDTH{sub}};
    assign x_c[0] = carry_in ^ sub;
    assign x_s[0] = '0;
    assign x_v[0] = in_valid;
`ifdef PIPE_ADD_SUB_SAT_EN
    assign x_sat[0] = sat;
`else
    assign x_sat[0] = 1'b0;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        if (k > 0) begin : g_link
            assign x_a[k]   = r_a[k-1];
            assign x_b[k]   = r_b[k-1];
            assign x_s[k]   = r_s[k-1];
            assign x_c[k]   = r_c[k-1];
            assign x_v[k]   = r_v[k-1];
            assign x_sat[k] = r_sat[k-1];
        end
        add_chunk #(.CW(CW)) u_add (
            .a   (x_a[k][k*CW +: CW]),
            .b   (x_b[k][k*CW +: CW]),
            .cin (x_c[k]),
            .s   (cs[k]),
            .cout(co[k])
        );
    end

    // Shift all stages together; each stage splices its chunk into the travelling sum, a stall freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_v[i]   <= 1'b0;
                r_a[i]   <= '0;
                r_b[i]   <= '0;
                r_s[i]   <= '0;
                r_c[i]   <= 1'b0;
                r_sat[i] <= 1'b0;
            end
        end else if (advance) begin
            for (int i = 0; i < STAGES; i++) begin
                r_v[i]              <= x_v[i];
                r_a[i]              <= x_a[i];
                r_b[i]              <= x_b[i];
                r_c[i]              <= co[i];
                r_sat[i]            <= x_sat[i];
                r_s[i]              <= x_s[i];
                r_s[i][i*CW +: CW]  <= cs[i];
            end
        end
    end

    assign raw          = r_s[L];
    assign fl.carry_out = r_c[L];
    assign fl.overflow  = signed_ovf(r_a[L][WIDTH-1], r_b[L][WIDTH-1], raw[WIDTH-1]);
    assign sum          = (r_sat[L] && fl.overflow) ? {~raw[WIDTH-1], {(WIDTH-1){raw[WIDTH-1]}}} : raw;
    assign fl.zero      = r_v[L] && (sum == '0);

    assign out_valid = r_v[L];
    assign carry_out = fl.carry_out;
    assign overflow  = fl.overflow;
    assign zero      = fl.zero;

endmodule

// File: tb/tb_pipe_add_sub.sv
// tb_pipe_add_sub: scoreboard bench for pipe_add_sub (16/4 main instance, 8/1 side instance)
module tb_pipe_add_sub;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        logic        z;
        int          t;
    } exp_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [15:0] a = 0;
    logic [15:0] b = 0;
    logic        sub = 0;
    logic        carry_in = 0;
    logic        out_valid;
    logic        out_ready = 1;
    logic [15:0] sum;
    logic        carry_out;
    logic        overflow;
    logic        zero;
`ifdef PIPE_ADD_SUB_SAT_EN
    logic        sat = 0;
    logic        sat8 = 0;
`endif

    logic        in_valid8 = 0;
    logic        in_ready8;
    logic [7:0]  a8 = 0;
    logic [7:0]  b8 = 0;
    logic        out_valid8;
    logic [7:0]  sum8;
    logic        carry_out8;
    logic        overflow8;
    logic        zero8;

    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    bit   rnd = 0;
    exp_t q[$];

    bit          held = 0;
    logic [15:0] h_sum;
    logic [2:0]  h_fl;

    pipe_add_sub #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .carry_in(carry_in),
`ifdef PIPE_ADD_SUB_SAT_EN
        .sat(sat),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    pipe_add_sub #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sub(1'b0), .carry_in(1'b0),
`ifdef PIPE_ADD_SUB_SAT_EN
        .sat(sat8),
`endif
        .out_valid(out_valid8), .out_ready(1'b1), .sum(sum8),
        .carry_out(carry_out8), .overflow(overflow8), .zero(zero8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    endtask

    function automatic exp_t mk(input logic [15:0] s, input logic c, input logic o, input logic z);
        exp_t e;
        e.s = s;
        e.c = c;
        e.o = o;
        e.z = z;
        e.t = -1;
        return e;
    endfunction

    // Reference: ideal signed result, unsigned carry/borrow, then clamp and zero
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic ms,
                                   input logic mci, input logic mst);
        exp_t e;
        int ia, ib, ua, ub, ic, id;
        ia = $signed(ma);
        ib = $signed(mb);
        ua = int'(ma);
        ub = int'(mb);
        ic = mci ? 1 : 0;
        id = ms ? ia - ib - ic : ia + ib + ic;
        e.o = (id > 32767) || (id < -32768);
        e.c = ms ? (ua >= ub + ic) : (ua + ub + ic > 65535);
        e.s = 16'(id);
        if (mst && e.o) e.s = (id > 0) ? 16'h7fff : 16'h8000;
        e.z = (e.s == 16'h0000);
        e.t = -1;
        return e;
    endfunction

    task automatic send(input logic [15:0] sa, input logic [15:0] sb, input logic ss, input logic sci,
                        input logic sst, input exp_t e, input bit timed);
        int n;
        n = 0;
        a = sa;
        b = sb;
        sub = ss;
        carry_in = sci;
`ifdef PIPE_ADD_SUB_SAT_EN
        sat = sst;
`endif
        in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        else begin
            e.t = timed ? cyc + 4 : -1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Monitor: handshake rule, stall stability, in-order scoreboard compare
    always @(negedge clk) begin
        if (rst) held = 0;
        else begin
            chk("in_ready_rule", int'(in_ready), int'(!(out_valid && !out_ready)));
            if (held) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_sum", int'(sum), int'(h_sum));
                chk("stall_flags", int'({carry_out, overflow, zero}), int'(h_fl));
            end
            held = out_valid && !out_ready;
            h_sum = sum;
            h_fl = {carry_out, overflow, zero};
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_output", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sum", int'(sum), int'(e.s));
                    chk("carry_out", int'(carry_out), int'(e.c));
                    chk("overflow", int'(overflow), int'(e.o));
                    chk("zero", int'(zero), int'(e.z));
                    if (e.t >= 0) chk("latency", cyc, e.t);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ra, rb;
        logic        rs, rc, rt;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_sum", int'(sum), 0);
        chk("reset_flags", int'({carry_out, overflow, zero}), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset8_out_valid", int'(out_valid8), 0);
        @(posedge clk);
        #1;

        send(16'hffff, 16'h0001, 0, 0, 0, mk(16'h0000, 1, 0, 1), 1);
`ifdef PIPE_ADD_SUB_SAT_EN
        send(16'h7fff, 16'h0001, 0, 0, 1, mk(16'h7fff, 0, 1, 0), 1);
        send(16'h8000, 16'h0001, 1, 0, 1, mk(16'h8000, 1, 1, 0), 1);
`else
        send(16'h7fff, 16'h0001, 0, 0, 0, mk(16'h8000, 0, 1, 0), 1);
        send(16'h8000, 16'h0001, 1, 0, 0, mk(16'h7fff, 1, 1, 0), 1);
`endif
        send(16'h0005, 16'h0007, 1, 0, 0, mk(16'hfffe, 0, 0, 0), 1);
        send(16'h0005, 16'h0007, 1, 1, 0, mk(16'hfffd, 0, 0, 0), 1);
        send(16'h1234, 16'h1234, 1, 0, 0, mk(16'h0000, 1, 0, 1), 1);

        rnd = 1;
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            rc = 1'($urandom);
            rt = 1'($urandom);
            if (i % 5 == 0) ra = 16'h7fff;
            if (i % 7 == 0) rb = 16'h8000;
`ifndef PIPE_ADD_SUB_SAT_EN
            rt = 0;
`endif
            send(ra, rb, rs, rc, rt, model(ra, rb, rs, rc, rt), 0);
        end
        for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
        chk("drain_stream", q.size(), 0);
        rnd = 0;
        repeat (2) @(posedge clk);
        #1;

        send(16'h0001, 16'h0002, 0, 0, 0, mk(16'h0003, 0, 0, 0), 0);
        send(16'h0003, 16'h0004, 0, 0, 0, mk(16'h0007, 0, 0, 0), 0);
        send(16'h0005, 16'h0006, 0, 0, 0, mk(16'h000b, 0, 0, 0), 0);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        q.delete();
        @(negedge clk);
        chk("post_reset_in_ready", int'(in_ready), 1);
        chk("post_reset_sum", int'(sum), 0);
        chk("post_reset_flags", int'({carry_out, overflow, zero}), 0);
        for (int i = 0; i < 6; i++) begin
            chk("post_reset_no_valid", int'(out_valid), 0);
            @(negedge clk);
        end

        @(posedge clk);
        #1;
        a8 = 8'h80;
        b8 = 8'h80;
        in_valid8 = 1;
        @(negedge clk);
        chk("w8_in_ready", int'(in_ready8), 1);
        @(posedge clk);
        #1;
        in_valid8 = 0;
        @(negedge clk);
        chk("w8_out_valid", int'(out_valid8), 1);
        chk("w8_sum", int'(sum8), 0);
        chk("w8_carry_out", int'(carry_out8), 1);
        chk("w8_overflow", int'(overflow8), 1);
        chk("w8_zero", int'(zero8), 1);
        @(negedge clk);
        chk("w8_out_valid_drop", int'(out_valid8), 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
